// File: rtl/gated_counter_spi.sv
// -----------------------------------------------------------------------------
// gated_counter_spi
//   Multi-channel gated event counter with a SPI-master frame output.
//   Each event input is synchronised and rising edges are counted. In gated
//   mode the counters restart on every measurement window (gate high). In
//   totalize mode they accumulate forever. On every gate falling edge the
//   counters are snapshotted and shipped out as one SPI mode-0 frame:
//     {seq, overrun, mode, ovf[CHANNELS-1:0], ch0, ch1, ...}, MSB first.
//
// Ports
//   clk      : single clock, everything on the rising edge
//   reset_n  : synchronous active-low reset
//   gate     : asynchronous measurement-window input (high = measure)
//   ev       : asynchronous event inputs, one per channel
//   mode     : 0 = gated (clear per window), 1 = totalize
//   ss_n     : SPI slave select, active low
//   sclk     : SPI clock, idle low
//   mosi     : SPI data, MSB first
//   done     : one-clk pulse when a frame has finished
//   busy     : high while a frame is being transmitted
// -----------------------------------------------------------------------------
module gated_counter_spi #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 2,
  parameter int CLKDIV   = 4,
  parameter int SEQ_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                gate,
  input  logic [CHANNELS-1:0] ev,
  input  logic                mode,
  output logic                ss_n,
  output logic                sclk,
  output logic                mosi,
  output logic                done,
  output logic                busy
);

  localparam int FRAME_BITS = SEQ_BITS + 2 + CHANNELS + CHANNELS * WIDTH;
  localparam int DIV_W      = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection. Bit CHANNELS carries the gate.
  // ---------------------------------------------------------------------------
  logic [CHANNELS:0] sync1, sync2, sync_d;
  logic [CHANNELS:0] rise, fall;
  logic [1:0]        warm;
  logic              armed;

  // Edges are suppressed until the pipeline holds real input samples, so an
  // input that is already high when reset releases is not seen as a rise.
  assign armed = (warm == 2'd3);
  assign rise  = armed ? (sync2 & ~sync_d) : '0;
  assign fall  = armed ? (~sync2 & sync_d) : '0;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sync_d <= '0;
      warm   <= '0;
    end else begin
      sync1  <= {gate, ev};
      sync2  <= sync1;
      sync_d <= sync2;
      if (!armed) warm <= warm + 2'd1;
    end
  end

  logic gate_lvl, gate_rise, gate_fall;
  assign gate_lvl  = sync2[CHANNELS];
  assign gate_rise = rise[CHANNELS];
  assign gate_fall = fall[CHANNELS];

  // ---------------------------------------------------------------------------
  // Counters, overflow and frame bookkeeping
  // ---------------------------------------------------------------------------
  state_t              state, state_nxt;
  logic [WIDTH-1:0]    cnt     [CHANNELS];
  logic [WIDTH-1:0]    cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0] sat, ovf;
  logic                overrun;
  logic [SEQ_BITS-1:0] seq, seq_inc;
  logic                take;

  assign busy    = (state != IDLE);
  assign take    = gate_fall & ~busy;
  assign seq_inc = seq + SEQ_BITS'(1);

  // NOTE: every combinational output gets a default before any branch, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    sat = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      cnt_nxt[c] = cnt[c];
      if (!mode && gate_rise) begin
        cnt_nxt[c] = WIDTH'(rise[c]);
      end else if ((mode || gate_lvl) && rise[c]) begin
        if (&cnt[c]) sat[c] = 1'b1;
        else         cnt_nxt[c] = cnt[c] + WIDTH'(1);
      end
    end
  end

  // The frame is assembled from next-cycle values so an edge or saturation
  // landing in the snapshot cycle is included.
  logic [FRAME_BITS-1:0] frame_load;
  always_comb begin
    frame_load = '0;
    frame_load[FRAME_BITS-1 -: SEQ_BITS]         = seq_inc;
    frame_load[CHANNELS*WIDTH + CHANNELS + 1]    = overrun;
    frame_load[CHANNELS*WIDTH + CHANNELS]        = mode;
    frame_load[CHANNELS*WIDTH +: CHANNELS]       = ovf | sat;
    for (int c = 0; c < CHANNELS; c++)
      frame_load[(CHANNELS-1-c)*WIDTH +: WIDTH] = cnt_nxt[c];
  end

  // NOTE: the counter array is reset element by element; it is a handful of
  // flops, not a RAM, so a reset loop is cheap and required here.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
      ovf     <= '0;
      overrun <= 1'b0;
      seq     <= '0;
    end else begin
      cnt <= cnt_nxt;
      if (take) begin
        // A saturation in the snapshot cycle stays flagged for the next frame.
        ovf     <= sat;
        overrun <= 1'b0;
        seq     <= seq_inc;
      end else begin
        ovf <= ovf | sat;
        if (gate_fall) overrun <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // SPI frame FSM
  // ---------------------------------------------------------------------------
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  sclk_q, done_q, tick, last_bit;

  assign tick     = (div_cnt == DIV_W'(CLKDIV - 1));
  assign last_bit = (bit_cnt == BIT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (take) state_nxt = SETUP;
      SETUP: if (tick) state_nxt = SHIFT;
      SHIFT: if (tick && sclk_q && last_bit) state_nxt = HOLD;
      HOLD:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q  <= (state == HOLD) && tick;
      div_cnt <= (state == IDLE || tick) ? '0 : div_cnt + DIV_W'(1);
      case (state)
        IDLE: begin
          if (take) begin
            shreg   <= frame_load;
            bit_cnt <= '0;
          end
        end
        SETUP: if (tick) sclk_q <= 1'b1;
        SHIFT: begin
          if (tick) begin
            if (sclk_q) begin
              // Data moves only on the falling edge; the last bit is held
              // through HOLD so mosi never changes at the final fall.
              sclk_q <= 1'b0;
              if (!last_bit) begin
                shreg   <= shreg << 1;
                bit_cnt <= bit_cnt + BIT_W'(1);
              end
            end else begin
              sclk_q <= 1'b1;
            end
          end
        end
        default: sclk_q <= 1'b0;
      endcase
    end
  end

  assign ss_n = (state == IDLE);
  assign sclk = sclk_q;
  assign mosi = (state != IDLE) & shreg[FRAME_BITS-1];
  assign done = done_q;

endmodule

// File: tb/tb_gated_counter_spi.sv
// -----------------------------------------------------------------------------
// tb_gated_counter_spi
//   Drives two instances in parallel (WIDTH=32 and WIDTH=4) from the same
//   gate/event stimulus, receives their SPI frames and compares every field
//   against a pulse-counting reference model. SPI timing of the 32-bit
//   instance is monitored continuously.
// -----------------------------------------------------------------------------
module tb_gated_counter_spi;

  localparam int CH = 2;
  localparam int SB = 8;
  localparam int CD = 4;
  localparam int WA = 32;
  localparam int WB = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          gate = 1'b0;
  logic          mode = 1'b0;
  logic [CH-1:0] ev = '0;
  logic          ss_n_a, sclk_a, mosi_a, done_a, busy_a;
  logic          ss_n_b, sclk_b, mosi_b, done_b, busy_b;

  always #5 clk = ~clk;

  gated_counter_spi #(.WIDTH(WA), .CHANNELS(CH), .CLKDIV(CD), .SEQ_BITS(SB)) u_a (
    .clk(clk), .reset_n(reset_n), .gate(gate), .ev(ev), .mode(mode),
    .ss_n(ss_n_a), .sclk(sclk_a), .mosi(mosi_a), .done(done_a), .busy(busy_a));

  gated_counter_spi #(.WIDTH(WB), .CHANNELS(CH), .CLKDIV(CD), .SEQ_BITS(SB)) u_b (
    .clk(clk), .reset_n(reset_n), .gate(gate), .ev(ev), .mode(mode),
    .ss_n(ss_n_b), .sclk(sclk_b), .mosi(mosi_b), .done(done_b), .busy(busy_b));

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- frame receivers and SPI timing monitor -------------------
  logic [127:0] rxsh [2];
  int           rxn  [2];
  logic [127:0] rxq  [2][$];
  int           rxl  [2][$];
  int           done_cnt [2];
  int           cyc = 0;
  bit           mon_en = 0;
  logic         psclk_a = 0, pssn_a = 1, pmosi_a = 0, psclk_b = 0, pssn_b = 1;
  int           t_ssn = 0, t_rise = -1, t_fall = 0, n_rises = 0;
  int           setup_bad = 0, period_bad = 0, hold_bad = 0, mosi_bad = 0, idle_bad = 0;

  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      if (!ss_n_a && pssn_a) begin rxsh[0] = '0; rxn[0] = 0; t_ssn = cyc; t_rise = -1; end
      if (!ss_n_a && sclk_a && !psclk_a) begin
        rxsh[0] = {rxsh[0][126:0], mosi_a};
        rxn[0]++;
        if (t_rise < 0) begin
          if (cyc - t_ssn != CD) setup_bad++;
        end else if (cyc - t_rise != 2 * CD) period_bad++;
        t_rise = cyc;
        n_rises++;
      end
      if (!ss_n_a && !sclk_a && psclk_a) t_fall = cyc;
      if (!ss_n_a && !pssn_a && (mosi_a !== pmosi_a) && !(psclk_a && !sclk_a)) mosi_bad++;
      if (ss_n_a && (sclk_a || mosi_a || busy_a)) idle_bad++;
      if (done_a) begin
        done_cnt[0]++;
        if ((cyc - t_fall != CD) || !ss_n_a) hold_bad++;
        rxq[0].push_back(rxsh[0]);
        rxl[0].push_back(rxn[0]);
      end
      if (!ss_n_b && pssn_b) begin rxsh[1] = '0; rxn[1] = 0; end
      if (!ss_n_b && sclk_b && !psclk_b) begin rxsh[1] = {rxsh[1][126:0], mosi_b}; rxn[1]++; end
      if (done_b) begin
        done_cnt[1]++;
        rxq[1].push_back(rxsh[1]);
        rxl[1].push_back(rxn[1]);
      end
    end
    psclk_a = sclk_a; pssn_a = ss_n_a; pmosi_a = mosi_a;
    psclk_b = sclk_b; pssn_b = ss_n_b;
  end

  // ---------------- reference model: pulses counted by the bench -------------
  typedef struct {
    int              seq;
    bit              ovr;
    bit              md;
    bit [1:0]        ovf;
    longint unsigned c0;
    longint unsigned c1;
  } exp_t;

  exp_t            expq [2][$];
  longint unsigned m_cnt [2][CH];
  bit              m_ovf [2][CH];
  int              m_seq;
  bit              m_ovr;
  bit              in_window;

  function automatic longint unsigned max_of(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'hF;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin m_cnt[d][c] = 0; m_ovf[d][c] = 0; end
      expq[d].delete(); rxq[d].delete(); rxl[d].delete();
    end
    m_seq = 0; m_ovr = 0; in_window = 0;
  endtask

  task automatic model_edge(input logic [CH-1:0] m);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++)
        if (m[c] && (mode || in_window)) begin
          if (m_cnt[d][c] == max_of(d)) m_ovf[d][c] = 1;
          else m_cnt[d][c]++;
        end
  endtask

  task automatic model_rise();
    in_window = 1;
    if (!mode)
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < CH; c++) m_cnt[d][c] = 0;
  endtask

  task automatic model_fall(input bit skipped);
    exp_t e;
    in_window = 0;
    if (skipped) begin
      m_ovr = 1;
    end else begin
      m_seq = (m_seq + 1) % 256;
      for (int d = 0; d < 2; d++) begin
        e.seq = m_seq; e.ovr = m_ovr; e.md = mode;
        e.ovf = {m_ovf[d][1], m_ovf[d][0]};
        e.c0 = m_cnt[d][0]; e.c1 = m_cnt[d][1];
        expq[d].push_back(e);
        for (int c = 0; c < CH; c++) m_ovf[d][c] = 0;
      end
      m_ovr = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [CH-1:0] m);
    ev = m; tick(2); ev = '0; tick(2);
    model_edge(m);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; tick(3); reset_n = 1'b1;
    model_reset(); tick(5);
  endtask

  task automatic window(input int n0, input int n1, input int len);
    int r0 = n0, r1 = n1, start;
    logic [1:0] m;
    start = cyc;
    gate = 1'b1; model_rise();
    tick(8);
    while (r0 > 0 || r1 > 0) begin
      m[0] = (r0 > 0) && ($urandom_range(0, 1) == 1);
      m[1] = (r1 > 0) && ($urandom_range(0, 1) == 1);
      if (m == 2'b00) m = (r0 > 0) ? 2'b01 : 2'b10;
      pulse(m);
      r0 -= int'(m[0]); r1 -= int'(m[1]);
      tick($urandom_range(0, 3));
    end
    tick(8);
    while (cyc - start < len) tick(1);
    gate = 1'b0; model_fall(0);
  endtask

  function automatic logic [63:0] fld(input logic [127:0] b, input int lsb, input int w);
    logic [127:0] msk;
    msk = (128'd1 << w) - 128'd1;
    return 64'((b >> lsb) & msk);
  endfunction

  task automatic compare_frame(input string tag, input int d);
    logic [127:0] b;
    int   n, w;
    exp_t e;
    string p;
    b = rxq[d].pop_front(); n = rxl[d].pop_front(); e = expq[d].pop_front();
    w = (d == 0) ? WA : WB;
    p = $sformatf("%s.%s", tag, (d == 0) ? "w32" : "w4");
    check({p, ".bits"},    64'(n), 64'(SB + 2 + CH + CH * w));
    check({p, ".seq"},     fld(b, 2 * w + 4, SB), 64'(e.seq));
    check({p, ".overrun"}, fld(b, 2 * w + 3, 1), 64'(e.ovr));
    check({p, ".mode"},    fld(b, 2 * w + 2, 1), 64'(e.md));
    check({p, ".ovf"},     fld(b, 2 * w, 2), 64'(e.ovf));
    check({p, ".ch0"},     fld(b, w, w), e.c0);
    check({p, ".ch1"},     fld(b, 0, w), e.c1);
  endtask

  task automatic wait_frames(input string tag);
    int budget = 3000;
    while (budget > 0 && (rxq[0].size() < expq[0].size() || rxq[1].size() < expq[1].size()
                          || busy_a || busy_b)) begin
      tick(1); budget--;
    end
    tick(2);
    check({tag, ".frames_w32"}, 64'(rxq[0].size()), 64'(expq[0].size()));
    check({tag, ".frames_w4"},  64'(rxq[1].size()), 64'(expq[1].size()));
    for (int d = 0; d < 2; d++) begin
      while (rxq[d].size() > 0 && expq[d].size() > 0) compare_frame(tag, d);
      rxq[d].delete(); rxl[d].delete(); expq[d].delete();
    end
  endtask

  // ---------------- directed sequence ---------------------------------------
  initial begin
    int d0, d1, r0, r1;
    for (int d = 0; d < 2; d++) begin done_cnt[d] = 0; rxn[d] = 0; rxsh[d] = '0; end
    model_reset();

    // Reset state
    do_reset();
    mon_en = 1;
    check("rst.ss_n",  64'(ss_n_a), 64'd1);
    check("rst.sclk",  64'(sclk_a), 64'd0);
    check("rst.mosi",  64'(mosi_a), 64'd0);
    check("rst.done",  64'(done_a), 64'd0);
    check("rst.busy",  64'(busy_a), 64'd0);
    check("rst.ss_n_w4", 64'(ss_n_b), 64'd1);
    check("rst.busy_w4", 64'(busy_b), 64'd0);

    // Gated window of 1000 clk with 37/5 events
    d0 = done_cnt[0];
    window(37, 5, 1000);
    wait_frames("gated37");
    check("gated37.done_once", 64'(done_cnt[0] - d0), 64'd1);

    // Saturation at WIDTH=4 and clearing in the following window
    window(20, 0, 0);
    wait_frames("sat20");
    window(3, 0, 0);
    wait_frames("after_sat");

    // Random gated windows
    for (int i = 0; i < 3; i++) begin
      window($urandom_range(0, 30), $urandom_range(0, 30), 0);
      wait_frames($sformatf("rand%0d", i));
    end

    // Totalize: two windows of 10 ev0, 4 more ev0 in between
    mode = 1'b1;
    do_reset();
    window(10, $urandom_range(0, 6), 0);
    wait_frames("tot1");
    for (int i = 0; i < 4; i++) pulse(2'b01);
    window(10, $urandom_range(0, 6), 0);
    wait_frames("tot2");

    // Second gate fall while busy: skipped, flagged as overrun next frame
    d0 = done_cnt[0]; d1 = done_cnt[1];
    window(5, 2, 0);
    tick(15);
    gate = 1'b1; model_rise();
    tick(20);
    check("ovr.busy_w32", 64'(busy_a), 64'd1);
    check("ovr.busy_w4",  64'(busy_b), 64'd1);
    gate = 1'b0; model_fall(1);
    wait_frames("ovr.first");
    tick(800);
    check("ovr.one_done_w32", 64'(done_cnt[0] - d0), 64'd1);
    check("ovr.one_done_w4",  64'(done_cnt[1] - d1), 64'd1);
    window(3, 1, 0);
    wait_frames("ovr.flagged");
    window(2, 2, 0);
    wait_frames("ovr.cleared");

    // Reset in the middle of SHIFT aborts the frame
    mode = 1'b0;
    do_reset();
    window(4, 4, 0);
    r0 = 2000;
    while (r0 > 0 && !(busy_a && rxn[0] >= 10)) begin tick(1); r0--; end
    check("abort.reached_shift", 64'(busy_a && rxn[0] >= 10), 64'd1);
    d0 = done_cnt[0]; d1 = done_cnt[1];
    reset_n = 1'b0;
    tick(1);
    check("abort.ss_n",    64'(ss_n_a), 64'd1);
    check("abort.sclk",    64'(sclk_a), 64'd0);
    check("abort.busy",    64'(busy_a), 64'd0);
    check("abort.ss_n_w4", 64'(ss_n_b), 64'd1);
    check("abort.sclk_w4", 64'(sclk_b), 64'd0);
    tick(2);
    reset_n = 1'b1;
    model_reset();
    tick(800);
    check("abort.no_done_w32", 64'(done_cnt[0] - d0), 64'd0);
    check("abort.no_done_w4",  64'(done_cnt[1] - d1), 64'd0);
    window(6, 3, 0);
    wait_frames("after_abort");

    // Gate and events already high at reset release are not edges
    reset_n = 1'b0; gate = 1'b1; ev = '1;
    tick(3);
    reset_n = 1'b1;
    model_reset();
    tick(12);
    ev = '0;
    tick(8);
    gate = 1'b0; model_fall(0);
    wait_frames("high_at_release");

    // SPI timing of the 32-bit instance across every frame
    r1 = (n_rises > 0) ? 1 : 0;
    check("spi.rises_seen",  64'(r1), 64'd1);
    check("spi.setup_len",   64'(setup_bad), 64'd0);
    check("spi.sclk_period", 64'(period_bad), 64'd0);
    check("spi.hold_len",    64'(hold_bad), 64'd0);
    check("spi.mosi_stable", 64'(mosi_bad), 64'd0);
    check("spi.idle_levels", 64'(idle_bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
